// File: rtl/mfcc_pkg.sv
// Shared types and constants for the spectral power scheduler:
// FSM states, the bin payload and the saturating add helper.
package mfcc_pkg;

    localparam int unsigned Q_DEFAULT        = 15;
    localparam int unsigned NUM_BINS_DEFAULT = 257;
    localparam int unsigned DATA_W           = 32;
    localparam logic [DATA_W-1:0] SAT_MAX    = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SQ_RE = 2'd1,
        ST_SQ_IM = 2'd2,
        ST_SUM   = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } bin_t;

    typedef struct packed {
        logic              sat;
        logic [DATA_W-1:0] value;
    } sat_res_t;

    // Add two non-negative squares in 33 bits and clamp to SAT_MAX.
    function automatic sat_res_t sat_add(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sat_res_t        res;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > (DATA_W+1)'(SAT_MAX)) begin
            res.sat   = 1'b1;
            res.value = SAT_MAX;
        end else begin
            res.sat   = 1'b0;
            res.value = sum[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pow_sq_unit.sv
// Registered saturating squarer: result = sat((x*x) >>> Q), updated when enabled.
module pow_sq_unit
    import mfcc_pkg::*;
#(
    parameter int unsigned Q = mfcc_pkg::Q_DEFAULT
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_operand,
    output logic        [DATA_W-1:0] o_result,
    output logic                     o_sat
);

    logic signed [2*DATA_W-1:0] w_op_ext;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [2*DATA_W-1:0] w_shift;
    logic                       w_clamp;

    assign w_op_ext = {{DATA_W{i_operand[DATA_W-1]}}, i_operand};
    assign w_prod   = w_op_ext * w_op_ext;
    assign w_shift  = w_prod >>> Q;
    // Square is never negative, so any set bit at or above bit 31 exceeds SAT_MAX.
    assign w_clamp  = |w_shift[2*DATA_W-1:DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            o_result <= '0;
            o_sat    <= 1'b0;
        end else if (i_en) begin
            o_result <= w_clamp ? SAT_MAX : w_shift[DATA_W-1:0];
            o_sat    <= w_clamp;
        end
    end

endmodule

// File: rtl/power_spec_sched.sv
// Per-bin spectral power |X|^2 using one shared squarer over a
// four-state schedule, with bin numbering, frame sync and sticky saturation.
module power_spec_sched
    import mfcc_pkg::*;
#(
    parameter int unsigned  Q        = mfcc_pkg::Q_DEFAULT,
    parameter int unsigned  NUM_BINS = mfcc_pkg::NUM_BINS_DEFAULT,
    localparam int unsigned BIN_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] fft_re,
    input  logic signed [DATA_W-1:0] fft_im,
    input  logic                     fft_valid,
    output logic                     fft_ready,
    input  logic                     frame_sync,
    output logic signed [DATA_W-1:0] power_out,
    output logic                     power_valid,
    output logic        [BIN_W-1:0]  bin_idx,
    output logic                     power_last,
    output logic                     sat_seen
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_hs;
    logic                w_sq_en;
    logic                w_cap_re;
    logic                w_sum_en;
    logic                w_sync;
    logic [DATA_W-1:0]   w_sq_op;

    bin_t                r_bin;
    logic [DATA_W-1:0]   r_sq_re;
    logic                r_sat_re;
    logic                r_ready;
    logic [DATA_W-1:0]   r_power;
    logic                r_power_valid;
    logic                r_power_last;
    logic [BIN_W-1:0]    r_bin_idx;
    logic [BIN_W-1:0]    r_bin_cnt;
    logic                r_sat_seen;
    logic                r_sync_pend;

    logic [DATA_W-1:0]   w_sq_result;
    logic                w_sq_sat;
    sat_res_t            w_add;
    logic                w_cnt_wrap;

    assign fft_ready   = r_ready;
    assign power_out   = r_power;
    assign power_valid = r_power_valid;
    assign power_last  = r_power_last;
    assign bin_idx     = r_bin_idx;
    assign sat_seen    = r_sat_seen;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and per-state datapath controls
    always_comb begin
        w_state_nxt = r_state;
        w_hs        = 1'b0;
        w_sq_en     = 1'b0;
        w_cap_re    = 1'b0;
        w_sum_en    = 1'b0;
        w_sq_op     = r_bin.re;
        case (r_state)
            ST_IDLE: begin
                if (fft_valid && r_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = ST_SQ_RE;
                end
            end
            ST_SQ_RE: begin
                w_sq_en     = 1'b1;
                w_sq_op     = r_bin.re;
                w_state_nxt = ST_SQ_IM;
            end
            ST_SQ_IM: begin
                w_sq_en     = 1'b1;
                w_cap_re    = 1'b1;
                w_sq_op     = r_bin.im;
                w_state_nxt = ST_SUM;
            end
            ST_SUM: begin
                w_sum_en    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A sync seen mid-bin is held until the in-flight result has been emitted.
    assign w_sync     = (r_state == ST_IDLE) && (frame_sync || r_sync_pend);
    assign w_add      = sat_add(r_sq_re, w_sq_result);
    assign w_cnt_wrap = (r_bin_cnt == BIN_W'(NUM_BINS - 1));

    pow_sq_unit #(.Q(Q)) u_sq (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_sq_en),
        .i_operand (w_sq_op),
        .o_result  (w_sq_result),
        .o_sat     (w_sq_sat)
    );

    // Operand capture and re-square holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin    <= '0;
            r_sq_re  <= '0;
            r_sat_re <= 1'b0;
        end else begin
            if (w_hs) begin
                r_bin.re <= fft_re;
                r_bin.im <= fft_im;
            end
            if (w_cap_re) begin
                r_sq_re  <= w_sq_result;
                r_sat_re <= w_sq_sat;
            end
        end
    end

    // Result, bin numbering and frame bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready       <= 1'b1;
            r_power       <= '0;
            r_power_valid <= 1'b0;
            r_power_last  <= 1'b0;
            r_bin_idx     <= '0;
            r_bin_cnt     <= '0;
            r_sat_seen    <= 1'b0;
            r_sync_pend   <= 1'b0;
        end else begin
            r_ready       <= (w_state_nxt == ST_IDLE);
            r_power_valid <= 1'b0;
            r_power_last  <= 1'b0;
            if (r_state == ST_IDLE) r_sync_pend <= 1'b0;
            else if (frame_sync)    r_sync_pend <= 1'b1;
            if (w_sync) begin
                r_bin_cnt  <= '0;
                r_sat_seen <= 1'b0;
            end
            if (w_sum_en) begin
                r_power       <= w_add.value;
                r_power_valid <= 1'b1;
                r_power_last  <= w_cnt_wrap;
                r_bin_idx     <= r_bin_cnt;
                r_bin_cnt     <= w_cnt_wrap ? '0 : r_bin_cnt + BIN_W'(1);
                if (r_sat_re || w_sq_sat || w_add.sat) r_sat_seen <= 1'b1;
            end
        end
    end

endmodule

// File: doc/power_spec_sched.md
POWER_SPEC_SCHED -- requirements
Module: power_spec_sched

Interface
REQ-001 Parameter Q, default 15: fractional bits of fft_re/fft_im and power_out.
REQ-002 Parameter NUM_BINS, default 257: bins per frame.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 fft_re  in  32  signed real part of bin, Q-format.
REQ-006 fft_im  in  32  signed imaginary part of bin, Q-format.
REQ-007 fft_valid  in  1  bin offered.
REQ-008 fft_ready  out  1  bin accepted when fft_valid && fft_ready.
REQ-009 frame_sync  in  1  restart bin numbering at 0 for the next accepted bin.
REQ-010 power_out  out  32  signed; re^2+im^2 in Q-format, saturated.
REQ-011 power_valid  out  1  power_out valid; one-cycle pulse.
REQ-012 bin_idx  out  ceil(log2(NUM_BINS))  bin number of power_out.
REQ-013 power_last  out  1  high with power_valid when bin_idx == NUM_BINS-1.
REQ-014 sat_seen  out  1  sticky saturation flag for current frame.

Function
REQ-015 One shared squarer is time-multiplexed between re and im; FSM states IDLE, SQ_RE, SQ_IM, SUM.
REQ-016 fft_ready SHALL be 1 only in IDLE; handshake latches fft_re/fft_im and moves IDLE->SQ_RE.
REQ-017 Transitions are unconditional: SQ_RE->SQ_IM->SUM->IDLE, one cycle each.
REQ-018 SQ_RE registers sq(re); SQ_IM registers sq(im); SUM registers power_out = sat(sq_re + sq_im).
REQ-019 Latency: handshake in cycle t -> power_valid high in cycle t+4; fft_ready high again in t+4; max throughput one bin per 4 cycles.
REQ-020 sq(x) = (64-bit signed x*x) >>> Q; if result > 0x7FFFFFFF, output 0x7FFFFFFF.
REQ-021 Sum of two non-negative terms is formed in 33 bits and clamps to 0x7FFFFFFF.
REQ-022 Any clamp in REQ-020/021 sets sat_seen.
REQ-023 No output backpressure; the downstream block always accepts power_valid.
REQ-024 The bin counter increments at each power_valid and wraps NUM_BINS-1 -> 0; power_last is asserted on the wrapping output.
REQ-025 frame_sync in IDLE (with or without a handshake that cycle) clears the bin counter and sat_seen, so the bin accepted that cycle is bin 0.
REQ-026 frame_sync outside IDLE applies after the in-flight bin's power_valid; the next bin is bin 0.
REQ-027 fft_valid outside IDLE is ignored; inputs are not sampled.
REQ-028 power_valid, power_last and fft_ready SHALL never be X after reset.

Reset
REQ-029 rst SHALL force: state IDLE; power_out 0; power_valid 0; power_last 0; bin_idx 0; sat_seen 0; pending frame_sync cleared; internal operand/square registers 0.
REQ-030 rst mid-operation SHALL abort the in-flight bin with no power_valid; fft_ready is 1 in the first cycle after rst deasserts.

Structure
REQ-031 The shared package mfcc_pkg holds Q default, NUM_BINS default, SAT_MAX = 0x7FFFFFFF and the FSM state enum.
REQ-032 A single sub-module, pow_sq_unit, is the registered saturating squarer (operand in, enable, result, sat flag).

Verification (Q=15)
REQ-033 re=32768, im=0, one handshake at cycle t -> power_out=32768, power_valid only at t+4, bin_idx=0, sat_seen=0.
REQ-034 re=-65536, im=65536 -> power_out=262144; sign-independence checked.
REQ-035 re=0x7FFFFFFF, im=0 -> power_out=0x7FFFFFFF, sat_seen=1; after frame_sync, sat_seen=0.
REQ-036 frame_sync, then 257 back-to-back bins with fft_valid held high -> handshakes every 4 cycles, bin_idx 0..256, power_last only on 256, next bin_idx=0.
REQ-037 fft_valid held high during SQ_RE..SUM with changing data -> only data present at the IDLE handshakes is used.
REQ-038 rst asserted in SQ_IM -> no power_valid, all outputs 0, fft_ready=1 in the first cycle after rst release, next bin_idx=0.
